// File: rtl/comm_sender.sv
// Serial transmitter toward the controller MCU: start bit, LSB-first data,
// odd parity, stop bit, then an enforced idle gap. The line idles high.
module comm_sender #(
    parameter int  packetBits = 8,
    parameter real clkFreq    = 74.25e6,
    parameter real usBit      = 10.0,
    parameter int  gapBits    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [packetBits-1:0] dataIn,
    input  logic                  valid,
    output logic                  ready,
    output logic                  serDatOut,
    output logic                  txDone
);

    localparam int bitTicks = int'(clkFreq * usBit / 1.0e6);
    localparam int tickW    = (bitTicks > 2) ? $clog2(bitTicks) : 1;
    localparam int bitW     = (packetBits > 1) ? $clog2(packetBits) : 1;

    localparam logic [tickW-1:0] tickLoad = tickW'(bitTicks - 1);
    localparam logic [bitW-1:0]  lastBit  = bitW'(packetBits - 1);
    localparam logic [3:0]       lastGap  = 4'((gapBits > 0) ? gapBits - 1 : 0);

    generate
        if (bitTicks < 2) begin : gBadTicks
            $error("comm_sender: bitTicks must be at least 2");
        end
        if (packetBits < 1 || packetBits > 16) begin : gBadBits
            $error("comm_sender: packetBits must be 1..16");
        end
        if (gapBits < 0 || gapBits > 15) begin : gBadGap
            $error("comm_sender: gapBits must be 0..15");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

    state_t                state;
    logic [tickW-1:0]      tickCnt;
    logic [bitW-1:0]       bitCnt;
    logic [3:0]            gapCnt;
    logic [packetBits-1:0] shiftReg;
    logic                  parity;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            serDatOut <= 1'b1;
            ready     <= 1'b0;
            txDone    <= 1'b0;
            tickCnt   <= '0;
            bitCnt    <= '0;
            gapCnt    <= '0;
            shiftReg  <= '0;
            parity    <= 1'b0;
        end else begin
            // Registered one cycle early so the pulse lands in the stop bit's final cycle.
            txDone <= (state == STOP) && (tickCnt == tickW'(1));

            if (state != IDLE) begin
                tickCnt <= (tickCnt == '0) ? tickLoad : tickCnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    serDatOut <= 1'b1;
                    ready     <= 1'b1;
                    if (valid && ready) begin
                        shiftReg  <= dataIn;
                        parity    <= ~^dataIn;
                        tickCnt   <= tickLoad;
                        ready     <= 1'b0;
                        serDatOut <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (tickCnt == '0) begin
                        serDatOut <= shiftReg[0];
                        shiftReg  <= shiftReg >> 1;
                        bitCnt    <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (tickCnt == '0) begin
                        if (bitCnt == lastBit) begin
                            serDatOut <= parity;
                            state     <= PARITY;
                        end else begin
                            bitCnt    <= bitCnt + 1'b1;
                            serDatOut <= shiftReg[0];
                            shiftReg  <= shiftReg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (tickCnt == '0) begin
                        serDatOut <= 1'b1;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (tickCnt == '0) begin
                        if (gapBits == 0) begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
                            gapCnt <= '0;
                            state  <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tickCnt == '0) begin
                        if (gapCnt == lastGap) begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
                            gapCnt <= gapCnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
